// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl
// Data-memory bus controller for the memory stage. Each load or store presented
// by the MW pipeline register becomes a single req/ack bus transaction. Store
// data and byte enables are lane-aligned here, and the pipeline is stalled until
// the access finishes. Loads return the raw 32-bit word; the load/store unit
// extracts and sign-extends it.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ld_req_i, st_req_i    load / store request levels (store wins if both are set)
//   size_i                00 byte, 01 half, 10 word, 11 invalid
//   addr_i, wdata_i       byte address, store data (value in the low bits)
//   stall_o               pipeline stall, low for exactly one cycle in DONE
//   rdata_o               raw read word, valid in DONE
//   err_o                 one-cycle pulse in DONE on timeout or misalignment
//   mem_req/we/addr/be/wdata   bus request side, held stable while BUSY
//   mem_ack, mem_rdata    bus completion (one cycle) and read data
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; latches bus fields when one arrives
// BUSY  | bus request outstanding; counting toward the timeout limit
// DONE  | one-cycle completion; stall released, err_o reported

module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_req_i,
    input  logic        st_req_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter holds the number of BUSY cycles already completed, so the
    // limit is hit in the cycle where it equals TIMEOUT_CYCLES-1.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic        err_flag;
    logic        req;
    logic        misaligned;
    logic        timeout;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;

    assign req     = ld_req_i | st_req_i;
    assign timeout = (cnt == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        case (size_i)
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = (addr_i[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata_i;
        case (size_i)
            2'b00: begin
                wdata_nxt = {4{wdata_i[7:0]}};
                if (st_req_i) be_nxt = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                wdata_nxt = {2{wdata_i[15:0]}};
                if (st_req_i) be_nxt = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_nxt = wdata_i;
                be_nxt    = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = misaligned ? S_DONE : S_BUSY;
            S_BUSY:  if (mem_ack || timeout) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gated by rst_n so the stall is forced low while reset is held,
    // even with a request pending.
    assign stall_o = rst_n & req & (state != S_DONE);
    assign err_o   = (state == S_DONE) & err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            err_flag  <= 1'b0;
            rdata_o   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        mem_addr  <= {addr_i[31:2], 2'b00};
                        mem_we    <= st_req_i;
                        mem_be    <= be_nxt;
                        mem_wdata <= wdata_nxt;
                        mem_req   <= ~misaligned;
                        err_flag  <= misaligned;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + 16'd1;
                    // An ack coinciding with the limit completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata_o <= mem_rdata;
                    end else if (timeout) begin
                        mem_req  <= 1'b0;
                        rdata_o  <= '0;
                        err_flag <= 1'b1;
                    end
                end
                S_DONE: begin
                    cnt      <= '0;
                    err_flag <= 1'b0;
                end
                default: begin
                    cnt      <= '0;
                    err_flag <= 1'b0;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule
